// File: rtl/tpu_pkg.sv
// Shared TPU definitions: the reader FSM state encoding and default buffer geometry.
package tpu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    localparam int DEFAULT_DATA_SIZE    = 8;
    localparam int DEFAULT_NUM_REGISTER = 256;

endpackage

// File: rtl/ofmap_reader_fifo.sv
// readout_fifo: two-entry synchronous FIFO with a registered head (no fall-through),
// used to absorb consumer backpressure behind the one-cycle buffer read.
module readout_fifo #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] push_data,
    input  logic             pop,
    output logic [width-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [width-1:0] head;
    logic [width-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign do_pop   = pop && (count != 2'd0);
    assign do_push  = push && ((count != 2'd2) || do_pop);
    assign pop_data = head;
    assign full     = (count == 2'd2);
    assign empty    = (count == 2'd0);

    // head always holds the oldest word; tail is only used when both entries are live
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b01: begin
                    head  <= tail;
                    count <= count - 2'd1;
                end
                2'b10: begin
                    if (count == 2'd0) head <= push_data;
                    else               tail <= push_data;
                    count <= count + 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/ofmap_reader.sv
// ofmap_reader: streams a contiguous unified-buffer region out as valid/ready beats.
// Define OFMAP_READER_WRAP_EN to let regions wrap past the top of the buffer.
module ofmap_reader
    import tpu_pkg::*;
#(
    parameter int dataSize    = DEFAULT_DATA_SIZE,
    parameter int numRegister = DEFAULT_NUM_REGISTER
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [$clog2(numRegister)-1:0] cfg_start_addr,
    input  logic [$clog2(numRegister):0]   cfg_length,
    input  logic                     ctrl_start,
    output logic                     rd_en,
    output logic [$clog2(numRegister)-1:0] rd_addr,
    input  logic [dataSize-1:0]      rd_data,
    output logic [dataSize-1:0]      out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_last,
    output logic                     flag_busy,
    output logic                     flag_done,
    output logic                     flag_err
);

    localparam int numAddrBuffer = $clog2(numRegister);

    state_t                   state;
    logic [numAddrBuffer-1:0] addr;
    logic [numAddrBuffer:0]   length;
    logic [numAddrBuffer:0]   issued;
    logic [numAddrBuffer:0]   beats;
    logic                     inflight;
    logic [1:0]               fifo_count;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic                     pop;
    logic                     room;
    logic                     issue;
    logic                     last_beat;
    logic                     reject;

`ifdef OFMAP_READER_WRAP_EN
    assign reject = 1'b0;
`else
    logic [numAddrBuffer+1:0] end_addr;
    assign end_addr = {2'b0, cfg_start_addr} + {1'b0, cfg_length};
    assign reject   = end_addr > (numAddrBuffer+2)'(numRegister);
`endif

    // a read may go out only if the word already held plus the one in flight
    // leaves a FIFO slot even if the consumer stalls from now on
    assign pop       = out_valid && out_ready;
    assign room      = (({1'b0, fifo_count} + {2'b0, inflight}) < ({2'b0, pop} + 3'd2))
                       && (!fifo_full || pop);
    assign issue     = (state == RUN) && (issued < length) && room;
    assign last_beat = (beats + 1'b1) == length;

    assign rd_en     = issue;
    assign rd_addr   = addr;
    assign out_valid = !fifo_empty;
    assign out_last  = out_valid && last_beat;
    assign flag_busy = (state != IDLE);

    readout_fifo #(
        .width(dataSize)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight),
        .push_data(rd_data),
        .pop      (pop),
        .pop_data (out_data),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            addr      <= '0;
            length    <= '0;
            issued    <= '0;
            beats     <= '0;
            inflight  <= 1'b0;
            flag_done <= 1'b0;
            flag_err  <= 1'b0;
        end else begin
            flag_done <= 1'b0;
            flag_err  <= 1'b0;
            inflight  <= issue;
            if (issue) begin
                addr   <= addr + 1'b1;
                issued <= issued + 1'b1;
            end
            if (pop) beats <= beats + 1'b1;

            case (state)
                IDLE: begin
                    if (ctrl_start) begin
                        if (reject) begin
                            flag_err <= 1'b1;
                        end else if (cfg_length == '0) begin
                            flag_done <= 1'b1;
                        end else begin
                            state  <= RUN;
                            addr   <= cfg_start_addr;
                            length <= cfg_length;
                            issued <= '0;
                            beats  <= '0;
                        end
                    end
                end
                RUN: begin
                    if (issue && ((issued + 1'b1) == length)) state <= DRAIN;
                end
                DRAIN: begin
                    if (pop && last_beat && (fifo_count == 2'd1) && !inflight) begin
                        state     <= IDLE;
                        flag_done <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
